// File: rtl/rf_2r1w_sync.sv
// Two-read, one-write register file with registered read ports, optional write-to-read bypass,
// synchronous clear-all and a read-valid strobe. Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module rf_2r1w_sync #(
    parameter int DW     = 4,
    parameter int AW     = 2,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          clr,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic          rvalid
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];
    logic          wr_en;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;

    // clr wins over a same-cycle write; with a zero register, writes to entry 0 are discarded
`ifdef RF_ZERO_REG_EN
    assign wr_en = we && !clr && (wa != '0);
`else
    assign wr_en = we && !clr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        a_next = regs[ra];
        b_next = regs[rb];
        if ((BYPASS != 0) && wr_en) begin
            if (wa == ra) begin
                a_next = wd;
            end
            if (wa == rb) begin
                b_next = wd;
            end
        end
`ifdef RF_ZERO_REG_EN
        if (ra == '0) begin
            a_next = '0;
        end
        if (rb == '0) begin
            b_next = '0;
        end
`endif
        // a read issued alongside clr sees the cleared file
        if (clr) begin
            a_next = '0;
            b_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                a <= a_next;
                b <= b_next;
            end
        end
    end

endmodule

// File: tb/tb_rf_2r1w_sync.sv
// Directed, table-driven bench for rf_2r1w_sync; one instance with bypass, one without,
// sharing the same stimulus. Expectations follow RF_ZERO_REG_EN when it is defined.
module tb_rf_2r1w_sync;

    logic       clk;
    logic       reset;
    logic       re;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       we;
    logic [1:0] wa;
    logic [3:0] wd;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       rvalid;
    logic [3:0] a_nb;
    logic [3:0] b_nb;
    logic       rvalid_nb;

    int n_vec;
    int n_miss;

    rf_2r1w_sync #(.DW(4), .AW(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .re(re), .ra(ra), .rb(rb),
        .we(we), .wa(wa), .wd(wd), .clr(clr),
        .a(a), .b(b), .rvalid(rvalid)
    );

    rf_2r1w_sync #(.DW(4), .AW(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .re(re), .ra(ra), .rb(rb),
        .we(we), .wa(wa), .wd(wd), .clr(clr),
        .a(a_nb), .b(b_nb), .rvalid(rvalid_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_ZERO_REG_EN
    localparam logic [3:0] R0_FIRST = 4'h0;
    localparam logic [3:0] R0_LATE  = 4'h0;
    localparam logic [3:0] BYP0     = 4'h0;
`else
    localparam logic [3:0] R0_FIRST = 4'hD;
    localparam logic [3:0] R0_LATE  = 4'hF;
    localparam logic [3:0] BYP0     = 4'hF;
`endif

    typedef struct {
        logic       re;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       we;
        logic [1:0] wa;
        logic [3:0] wd;
        logic       clr;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ea_nb;
        logic [3:0] eb_nb;
        logic       erv;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] xa, input logic [1:0] xb,
                                input logic w, input logic [1:0] xw, input logic [3:0] d,
                                input logic c, input logic [3:0] ea, input logic [3:0] eb,
                                input logic [3:0] ean, input logic [3:0] ebn, input logic erv);
        vec_t v;
        v.re = r;  v.ra = xa; v.rb = xb; v.we = w; v.wa = xw; v.wd = d; v.clr = c;
        v.ea = ea; v.eb = eb; v.ea_nb = ean; v.eb_nb = ebn; v.erv = erv;
        return v;
    endfunction

    task automatic apply_stimulus(input logic r, input logic [1:0] xa, input logic [1:0] xb,
                                  input logic w, input logic [1:0] xw, input logic [3:0] d,
                                  input logic c);
        re = r; ra = xa; rb = xb; we = w; wa = xw; wd = d; clr = c;
    endtask

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic [3:0] ean, input logic [3:0] ebn, input logic erv);
        check_output({tag, "_a"}, a, ea);
        check_output({tag, "_b"}, b, eb);
        check_output({tag, "_rvalid"}, {3'b0, rvalid}, {3'b0, erv});
        check_output({tag, "_a_nb"}, a_nb, ean);
        check_output({tag, "_b_nb"}, b_nb, ebn);
        check_output({tag, "_rvalid_nb"}, {3'b0, rvalid_nb}, {3'b0, erv});
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        //               re ra rb   we wa wd  clr  ea   eb   ea_nb eb_nb rv
        vecs[0]  = mk(1, 0, 3, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[1]  = mk(1, 1, 2, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[2]  = mk(1, 2, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[3]  = mk(1, 3, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0, 4'hD, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 2, 4'hA, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[7]  = mk(0, 0, 0, 1, 3, 4'h7, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[8]  = mk(1, 1, 2, 0, 0, 4'h0, 0, 4'h3, 4'hA, 4'h3, 4'hA, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 4'hA, 4'h3, 4'hA, 0);
        vecs[10] = mk(1, 0, 3, 0, 0, 4'h0, 0, R0_FIRST, 4'h7, R0_FIRST, 4'h7, 1);
        // bypass: same-cycle write to reg 2 read on both ports
        vecs[11] = mk(1, 2, 2, 1, 2, 4'h5, 0, 4'h5, 4'h5, 4'hA, 4'hA, 1);
        vecs[12] = mk(1, 2, 0, 0, 0, 4'h0, 0, 4'h5, R0_FIRST, 4'h5, R0_FIRST, 1);
        vecs[13] = mk(1, 3, 1, 0, 0, 4'h0, 0, 4'h7, 4'h3, 4'h7, 4'h3, 1);
        // clr with a competing write and a read: write dropped, read returns zero
        vecs[14] = mk(1, 3, 1, 1, 3, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[16] = mk(0, 0, 0, 1, 1, 4'h9, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[17] = mk(1, 1, 1, 0, 0, 4'h0, 0, 4'h9, 4'h9, 4'h9, 4'h9, 1);
        // clr without re leaves a/b untouched
        vecs[18] = mk(0, 0, 0, 0, 0, 4'h0, 1, 4'h9, 4'h9, 4'h9, 4'h9, 0);
        vecs[19] = mk(1, 1, 2, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[20] = mk(1, 0, 3, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        vecs[21] = mk(1, 0, 1, 1, 0, 4'hF, 0, BYP0, 4'h0, 4'h0, 4'h0, 1);
        vecs[22] = mk(1, 0, 0, 0, 0, 4'h0, 0, R0_LATE, R0_LATE, R0_LATE, R0_LATE, 1);
        vecs[23] = mk(0, 0, 0, 0, 1, 4'h6, 0, R0_LATE, R0_LATE, R0_LATE, R0_LATE, 0);
        vecs[24] = mk(1, 1, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);

        apply_stimulus(0, 0, 0, 0, 0, 4'h0, 0);
        reset = 1'b0;
        #2 reset = 1'b1;
        #1 check_all("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 check_all("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].re, vecs[i].ra, vecs[i].rb, vecs[i].we,
                           vecs[i].wa, vecs[i].wd, vecs[i].clr);
            @(posedge clk);
            #1 check_all($sformatf("v%0d", i), vecs[i].ea, vecs[i].eb,
                         vecs[i].ea_nb, vecs[i].eb_nb, vecs[i].erv);
        end

        // asynchronous reset in the middle of back-to-back reads
        @(negedge clk);
        apply_stimulus(0, 0, 0, 1, 2, 4'hC, 0);
        @(negedge clk);
        apply_stimulus(1, 2, 2, 0, 0, 4'h0, 0);
        @(posedge clk);
        #1 check_all("mid_read", 4'hC, 4'hC, 4'hC, 4'hC, 1'b1);
        @(posedge clk);
        #1 check_all("mid_read2", 4'hC, 4'hC, 4'hC, 4'hC, 1'b1);
        #2 reset = 1'b1;
        #1 check_all("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1 check_all("mid_reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply_stimulus(1, 2'(i), 2'(3 - i), 0, 0, 4'h0, 0);
            @(posedge clk);
            #1 check_all($sformatf("post_reset%0d", i), 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rf_2r1w_sync.md
Name: rf_2r1w_sync

Overview:
- Parametrised register file: DEPTH = 2**AW entries, each DW bits.
- Two registered read ports (A, B) and one synchronous write port.
- Adds write-to-read bypass, a synchronous clear-all command and a read-valid strobe.
- Sits between the decode stage (supplies addresses) and the ALU (consumes A/B) in the lab datapath.

Parameters:
- DW, 4, data width of each register and of wd/a/b.
- AW, 2, address width; register count DEPTH = 2**AW.
- BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns the pre-write contents.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- re  in  1  read enable; samples ra/rb this cycle, results on a/b next cycle.
- ra  in  AW  read address, port A.
- rb  in  AW  read address, port B.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- clr  in  1  synchronous clear of all registers.
- a  out  DW  registered read data, port A.
- b  out  DW  registered read data, port B.
- rvalid  out  1  high for one cycle when a/b hold data from a read issued the previous cycle.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all DEPTH registers = 0; a = 0, b = 0, rvalid = 0.
  - State holds while reset is high; normal operation resumes on the first rising edge after reset falls.
- Write:
  - At rising edge with we=1 and clr=0: reg[wa] <= wd.
  - we=0: no register changes.
- Read (latency 1):
  - At rising edge with re=1: a <= value(ra), b <= value(rb), rvalid <= 1.
  - With re=0: a and b hold their previous values, rvalid <= 0.
  - Back-to-back reads give one result per cycle; rvalid stays high.
- value(x):
  - Normally reg[x].
  - If BYPASS=1, we=1, clr=0 and wa==x in the same cycle: value(x) = wd (new data).
  - If BYPASS=0: value(x) = reg[x] as it stood before the edge (old data).
- ra==rb: both ports return the same value, including the bypass case.
- Clear:
  - At rising edge with clr=1: all registers <= 0.
  - clr has priority over we; the same-cycle write is dropped.
  - A read issued in the clr cycle returns 0 on both ports (rvalid=1).
  - a/b are not cleared by clr unless re=1.
- Widths: addresses are full-range (no out-of-range case); no arithmetic performed; data stored unmodified.

Optional Feature:
- Macro: RF_ZERO_REG_EN
- Defined:
  - register 0 is hardwired to zero.
  - Writes with wa==0 are ignored.
  - Reads of address 0 always return 0, including when bypass would apply.
  - Implementation may omit storage for entry 0.
- Not defined: register 0 is an ordinary storage entry.

Test Plan (DW=4, AW=2, BYPASS=1 unless stated):
- Reset then reads:
  - Assert reset mid-cycle, release, re=1, ra=0..3, rb=3..0 -> a=b=0000 each cycle.
  - rvalid=0 during reset, 1 from the cycle after the first re.
- Write then read:
  - Write 1101, 0011, 1010, 0111 to regs 0..3 (we=1, re=0).
  - Then re=1, ra=1, rb=2 -> next cycle a=0011, b=1010, rvalid=1.
  - Drop re -> a/b hold, rvalid=0.
- Bypass:
  - Reg 2 = 1010; same cycle we=1, wa=2, wd=0101, re=1, ra=2, rb=2 -> a=b=0101.
  - Rebuild with BYPASS=0 -> a=b=1010, then a later read returns 0101.
- Clear priority:
  - Regs loaded; one cycle clr=1, we=1, wa=3, wd=1111, re=1, ra=3 -> a=0000.
  - Following read of regs 0..3 -> all 0000.
- Reset mid-operation:
  - During back-to-back reads with rvalid=1, assert reset asynchronously between edges -> a=b=0, rvalid=0 immediately, all regs read 0 afterwards.
- With RF_ZERO_REG_EN:
  - Write 1111 to reg 0 and 1001 to reg 1; read ra=0, rb=1 -> a=0000, b=1001.
  - Same-cycle bypass to address 0 -> a=0000.
